// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, constants, saturation and twiddle helpers for the FFT stages
// Purpose: common definitions imported by the radix-2 butterfly and its twiddle ROM.
// Ports: none (package).
package fft_pkg;

  localparam int DW      = 24;     // complex component width, signed
  localparam int TW      = 16;     // twiddle component width, signed Q2.14
  localparam int N       = 1024;   // FFT size
  localparam int HALF    = N / 2;  // delay-line depth of the first stage
  localparam int Q14_ONE = 16384;  // +1.0 in Q2.14
  localparam int FRAC    = 14;     // fractional bits of a twiddle
  localparam int RND     = 8192;   // half an LSB after the Q2.14 shift

  localparam real PI = 3.14159265358979323846;

  // Saturation bounds expressed at the widest intermediate width (DW+TW+1).
  localparam logic signed [DW+TW:0] SAT_MAX = {{(TW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [DW+TW:0] SAT_MIN = {{(TW+2){1'b1}}, {(DW-1){1'b0}}};

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Clamp any sign-extended DW+k value (k <= TW+1) to DW bits.
  function automatic logic signed [DW-1:0] sat(input logic signed [DW+TW:0] x);
    if (x > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (x < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end else begin
      return x[DW-1:0];
    end
  endfunction

  // Round half away from zero; only evaluated at elaboration to build the ROM.
  function automatic logic signed [TW-1:0] tw_round(input real v);
    int r;
    if (v >= 0.0) begin
      r = $rtoi(v + 0.5);
    end else begin
      r = -$rtoi(-v + 0.5);
    end
    return TW'(r);
  endfunction

endpackage

// File: rtl/twiddle_rom_512.sv
// rtl/twiddle_rom_512.sv - combinational W^k = exp(-j2*pi*k/1024) lookup for k in 0..511
// Purpose: returns c = round(16384*cos(2*pi*k/N)), d = -round(16384*sin(2*pi*k/N)).
// Ports:
//   i_addr  in   9   twiddle index k
//   o_c     out  TW  real part, Q2.14
//   o_d     out  TW  imaginary part, Q2.14
module twiddle_rom_512
  import fft_pkg::*;
(
  input  logic [8:0]           i_addr,
  output logic signed [TW-1:0] o_c,
  output logic signed [TW-1:0] o_d
);

  logic signed [TW-1:0] w_c_tab [HALF];
  logic signed [TW-1:0] w_d_tab [HALF];

  // Every entry is an elaboration-time constant; the table folds into logic.
  for (genvar g = 0; g < HALF; g++) begin : g_tab
    localparam real ANG = 2.0 * PI * real'(g) / real'(N);
    assign w_c_tab[g] = tw_round(real'(Q14_ONE) * $cos(ANG));
    assign w_d_tab[g] = tw_round(-real'(Q14_ONE) * $sin(ANG));
  end

  assign o_c = w_c_tab[i_addr];
  assign o_d = w_d_tab[i_addr];

endmodule

// File: rtl/radix2_bf_512.sv
// rtl/radix2_bf_512.sv - radix-2 SDF butterfly for the first stage of the 1024-point FFT
// Purpose: pairs with an external 512-deep delay line. Phase A (cnt[9]=0) fills the delay
//   line with din and emits the twiddle-rotated differences of the previous frame; phase B
//   emits butterfly sums and writes butterfly differences back into the delay line.
// Ports:
//   clk, rst_n           in   1   clock, asynchronous active-low reset
//   in_valid             in   1   upstream sample strobe
//   din_r, din_i         in   DW  upstream sample
//   dly_r, dly_i         in   DW  delay-line output
//   to_dly_r, to_dly_i   out  DW  delay-line input (combinational)
//   dly_en               out  1   delay-line shift strobe
//   dout_r, dout_i       out  DW  stage output (registered, 2-cycle latency)
//   out_valid            out  1   output strobe (registered)
module radix2_bf_512
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] dly_r,
  input  logic signed [DW-1:0] dly_i,
  output logic signed [DW-1:0] to_dly_r,
  output logic signed [DW-1:0] to_dly_i,
  output logic                 dly_en,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i,
  output logic                 out_valid
);

  logic [9:0]           r_cnt;
  logic                 r_running;
  logic                 r_seen_b;   // first phase B reached: delay line holds real data
  cplx_t                r_op;
  logic signed [TW-1:0] r_c;
  logic signed [TW-1:0] r_d;
  logic                 r_byp;
  logic                 r_v1;

  logic                 w_adv;
  logic                 w_phase_b;
  logic signed [DW-1:0] w_din_r, w_din_i;
  logic signed [DW:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic signed [DW-1:0] w_sum_sat_r, w_sum_sat_i, w_dif_sat_r, w_dif_sat_i;
  cplx_t                w_op;
  logic signed [TW-1:0] w_tw_c, w_tw_d;

  assign w_adv     = in_valid | r_running;
  assign dly_en    = w_adv;
  assign w_phase_b = r_cnt[9];

  // Flush cycles feed zeros; before the first sample din passes through untouched.
  assign w_din_r = (!in_valid && r_running) ? '0 : din_r;
  assign w_din_i = (!in_valid && r_running) ? '0 : din_i;

  assign w_sum_r = {dly_r[DW-1], dly_r} + {w_din_r[DW-1], w_din_r};
  assign w_sum_i = {dly_i[DW-1], dly_i} + {w_din_i[DW-1], w_din_i};
  assign w_dif_r = {dly_r[DW-1], dly_r} - {w_din_r[DW-1], w_din_r};
  assign w_dif_i = {dly_i[DW-1], dly_i} - {w_din_i[DW-1], w_din_i};

  assign w_sum_sat_r = sat({{TW{w_sum_r[DW]}}, w_sum_r});
  assign w_sum_sat_i = sat({{TW{w_sum_i[DW]}}, w_sum_i});
  assign w_dif_sat_r = sat({{TW{w_dif_r[DW]}}, w_dif_r});
  assign w_dif_sat_i = sat({{TW{w_dif_i[DW]}}, w_dif_i});

  assign to_dly_r = w_phase_b ? w_dif_sat_r : w_din_r;
  assign to_dly_i = w_phase_b ? w_dif_sat_i : w_din_i;
  assign w_op.re  = w_phase_b ? w_sum_sat_r : dly_r;
  assign w_op.im  = w_phase_b ? w_sum_sat_i : dly_i;

  twiddle_rom_512 u_rom (
    .i_addr (r_cnt[8:0]),
    .o_c    (w_tw_c),
    .o_d    (w_tw_d)
  );

  // Stage-2 complex multiply (a + jb)(c + jd) with round-half-up and saturation.
  logic signed [DW-1:0]    w_a, w_b;
  logic signed [DW+TW-1:0] w_ac, w_bd, w_ad, w_bc;
  logic signed [DW+TW:0]   w_re_acc, w_im_acc, w_re_sh, w_im_sh;
  logic signed [DW-1:0]    w_rot_r, w_rot_i;

  assign w_a  = r_op.re;
  assign w_b  = r_op.im;
  assign w_ac = w_a * r_c;
  assign w_bd = w_b * r_d;
  assign w_ad = w_a * r_d;
  assign w_bc = w_b * r_c;

  assign w_re_acc = {w_ac[DW+TW-1], w_ac} - {w_bd[DW+TW-1], w_bd} + (DW+TW+1)'(RND);
  assign w_im_acc = {w_ad[DW+TW-1], w_ad} + {w_bc[DW+TW-1], w_bc} + (DW+TW+1)'(RND);
  assign w_re_sh  = w_re_acc >>> FRAC;
  assign w_im_sh  = w_im_acc >>> FRAC;
  assign w_rot_r  = sat(w_re_sh);
  assign w_rot_i  = sat(w_im_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_seen_b  <= 1'b0;
      r_op      <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_byp     <= 1'b0;
      r_v1      <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
      out_valid <= 1'b0;
    end else if (w_adv) begin
      r_cnt     <= r_cnt + 10'd1;
      r_running <= 1'b1;
      if (w_phase_b) begin
        r_seen_b <= 1'b1;
      end
      r_op      <= w_op;
      r_c       <= w_tw_c;
      r_d       <= w_tw_d;
      r_byp     <= w_phase_b;
      // Frame-0 phase A reads an empty delay line, so it never produces output.
      r_v1      <= w_phase_b | r_seen_b;
      out_valid <= r_v1;
      dout_r    <= r_byp ? r_op.re : w_rot_r;
      dout_i    <= r_byp ? r_op.im : w_rot_i;
    end
  end

endmodule

// File: tb/tb_radix2_bf_512.sv
// tb/tb_radix2_bf_512.sv - self-checking bench for radix2_bf_512 with a 512-deep delay line in the loop
module tb_radix2_bf_512;

  localparam int DW = 24;
  localparam real PI = 3.14159265358979323846;
  localparam int NEV = 16384;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] din_r = '0, din_i = '0;
  logic signed [DW-1:0] dly_r, dly_i, to_dly_r, to_dly_i, dout_r, dout_i;
  logic                 dly_en, out_valid;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  radix2_bf_512 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .dly_r     (dly_r),
    .dly_i     (dly_i),
    .to_dly_r  (to_dly_r),
    .to_dly_i  (to_dly_i),
    .dly_en    (dly_en),
    .dout_r    (dout_r),
    .dout_i    (dout_i),
    .out_valid (out_valid)
  );

  // 512-deep delay line: a value written on one shift reappears 512 shifts later.
  logic signed [DW-1:0] dl_r [512];
  logic signed [DW-1:0] dl_i [512];
  logic [8:0]           dl_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_p <= '0;
      for (int k = 0; k < 512; k++) begin
        dl_r[k] <= '0;
        dl_i[k] <= '0;
      end
    end else if (dly_en) begin
      dl_r[dl_p] <= to_dly_r;
      dl_i[dl_p] <= to_dly_i;
      dl_p       <= dl_p + 9'd1;
    end
  end

  assign dly_r = dl_r[dl_p];
  assign dly_i = dl_i[dl_p];

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint xr[$], xi[$];          // effective samples, one per advance since reset
  bit     running_m;
  int     pc;
  bit     ev [NEV];
  longint er [NEV];
  longint ei [NEV];
  int     out_idx;
  int     first_pc;
  bit     started;
  bit     stream_a;

  int     dj [12]  = '{0, 511, 512, 1023, 1024, 1324, 1536, 1792, 2048, 2049, 2176, 2688};
  longint dre [12] = '{200, 200, 0, 0, 0, 300, 0, 0, 8388607, -1, 1000, 707};
  longint dim [12] = '{0, 0, 0, 0, 0, 0, 0, -256, 0, 0, 0, -707};

  function automatic longint satm(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic longint rndr(input real v);
    if (v >= 0.0) return longint'($floor(v + 0.5));
    return -longint'($floor(-v + 0.5));
  endfunction

  function automatic void rotm(input longint a, input longint b, input int k,
                               output longint re, output longint im);
    longint c, d;
    c  = rndr(16384.0 * $cos(2.0 * PI * real'(k) / 1024.0));
    d  = -rndr(16384.0 * $sin(2.0 * PI * real'(k) / 1024.0));
    re = satm((a * c - b * d + 8192) >>> 14);
    im = satm((a * d + b * c + 8192) >>> 14);
  endfunction

  function automatic longint rnd24();
    case ($urandom_range(7))
      0:       return 8388607;
      1:       return -8388608;
      2:       return longint'($signed(10'($urandom)));
      default: return longint'($signed(24'($urandom)));
    endcase
  endfunction

  task automatic model_reset();
    xr.delete();
    xi.delete();
    running_m = 1'b0;
    out_idx   = 0;
    started   = 1'b0;
    for (int k = 0; k < NEV; k++) ev[k] = 1'b0;
  endtask

  // Called at a falling edge: drive one cycle of input, check, advance to the next falling edge.
  task automatic step(input bit v, input longint r, input longint i);
    longint eff_r, eff_i, et_r, et_i, a, b, pr, pi;
    int s, c;
    in_valid = v;
    din_r    = DW'(r);
    din_i    = DW'(i);
    eff_r = (!v && running_m) ? 0 : r;
    eff_i = (!v && running_m) ? 0 : i;
    s = xr.size();
    c = s % 1024;
    if (c < 512) begin
      et_r = eff_r;
      et_i = eff_i;
    end else begin
      et_r = satm(xr[s-512] - eff_r);
      et_i = satm(xi[s-512] - eff_i);
    end
    #1;
    check("to_dly_r", to_dly_r, et_r);
    check("to_dly_i", to_dly_i, et_i);
    check("dly_en", dly_en, longint'(v || running_m));
    if (stream_a && s == 2561) check("diff_sat", to_dly_r, 8388607);
    if (rst_n && v && !started) begin
      started  = 1'b1;
      first_pc = pc;
    end
    @(posedge clk);
    pc++;
    if (rst_n && (v || running_m)) begin
      running_m = 1'b1;
      xr.push_back(eff_r);
      xi.push_back(eff_i);
      if (c >= 512) begin
        ev[pc+1] = 1'b1;
        er[pc+1] = satm(xr[s-512] + xr[s]);
        ei[pc+1] = satm(xi[s-512] + xi[s]);
      end else if (s >= 1024) begin
        a = satm(xr[s-1024] - xr[s-512]);
        b = satm(xi[s-1024] - xi[s-512]);
        rotm(a, b, c, pr, pi);
        ev[pc+1] = 1'b1;
        er[pc+1] = pr;
        ei[pc+1] = pi;
      end
    end
    @(negedge clk);
    check("out_valid", out_valid, longint'(ev[pc]));
    if (ev[pc]) begin
      check("dout_r", dout_r, er[pc]);
      check("dout_i", dout_i, ei[pc]);
      if (out_idx == 0) check("first_latency", longint'(pc - first_pc), 514);
      if (stream_a) begin
        for (int t = 0; t < 12; t++) begin
          if (dj[t] == out_idx) begin
            check("dir_r", dout_r, dre[t]);
            check("dir_i", dout_i, dim[t]);
          end
        end
      end
      out_idx++;
    end
  endtask

  initial begin
    pc       = 0;
    first_pc = 0;
    stream_a = 1'b0;
    model_reset();

    // Reset state
    din_r = 24'sd12345;
    din_i = -24'sd77;
    @(negedge clk);
    check("rst_dout_r", dout_r, 0);
    check("rst_dout_i", dout_i, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_to_dly_r", to_dly_r, 12345);
    check("rst_to_dly_i", to_dly_i, -77);
    step(1'b0, rnd24(), rnd24());
    rst_n = 1'b1;
    step(1'b0, rnd24(), rnd24());

    // Directed frames: constant, half ramp, rounding/saturation, then one random frame
    stream_a = 1'b1;
    for (int n = 0; n < 1024; n++) step(1'b1, 100, 0);
    for (int n = 0; n < 1024; n++) step(1'b1, (n < 512) ? n : 0, 0);
    for (int n = 0; n < 1024; n++) begin
      longint v;
      case (n)
        0, 1, 512: v = 8388607;
        128:       v = 1000;
        513:       v = -8388608;
        default:   v = 0;
      endcase
      step(1'b1, v, 0);
    end
    for (int n = 0; n < 1024; n++) step(1'b1, rnd24(), rnd24());

    // Flush with garbage on din while in_valid is low, until cnt reaches 700
    while ((xr.size() % 1024) != 700) step(1'b0, rnd24(), rnd24());
    stream_a = 1'b0;

    // Asynchronous reset mid-frame
    rst_n = 1'b0;
    #1;
    check("arst_dout_r", dout_r, 0);
    check("arst_dout_i", dout_i, 0);
    check("arst_out_valid", out_valid, 0);
    model_reset();
    for (int n = 0; n < 3; n++) step(1'b0, rnd24(), rnd24());
    rst_n = 1'b1;

    // Gapped start: one pulse, idle, then a random two-frame stream and flush
    for (int n = 0; n < 10; n++) step(1'b0, rnd24(), rnd24());
    step(1'b1, rnd24(), rnd24());
    for (int n = 0; n < 39; n++) step(1'b0, rnd24(), rnd24());
    for (int n = 0; n < 2048; n++) step(1'b1, rnd24(), rnd24());
    for (int n = 0; n < 1100; n++) step(1'b0, rnd24(), rnd24());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
